// File: rtl/arb_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
package arb_pkg;

  // Arbiter FSM states: one transaction in flight at a time.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    ERR_I  = 3'd3,
    ERR_D  = 3'd4
  } arb_state_t;

  // Requester identity used for the arbitration decision.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  // A word access is misaligned when either low byte-address bit is set.
  function automatic logic misaligned(input logic [1:0] lsbs);
    return (lsbs != 2'b00);
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive arbitration decisions lost by the fetch side.
module arb_starve_cnt #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic starve
);

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt;

  // Count denied fetch decisions, saturating at MAX_WAIT; clear wins over inc.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < CW'(MAX_WAIT))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starve = (cnt >= CW'(MAX_WAIT));

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates a single-port word memory between instruction fetch (I) and
// load/store (D). D has priority; a starvation counter lets I win after
// MAX_WAIT consecutive losses. Misaligned requests complete with an error
// without touching memory.
module imem_dmem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t        state;
  arb_state_t        state_nx;
  logic              starve;
  logic              decide;
  req_id_t           winner;
  logic [ADDR_W-1:0] win_addr;
  logic              win_mis;
  logic              i_gnt_nx, d_gnt_nx;
  logic              i_fin, d_fin;
  logic              i_err_nx, d_err_nx;
  logic              i_load, d_load;
  logic              mem_load;
  logic              cnt_inc, cnt_clr;

  arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .starve  (starve)
  );

  // Arbitration decision: D wins unless I is waiting and has starved.
  always_comb begin
    decide   = (state == IDLE) && (i_req || d_req);
    winner   = (d_req && !(i_req && starve)) ? REQ_D : REQ_I;
    win_addr = (winner == REQ_D) ? d_addr : i_addr;
    win_mis  = misaligned(win_addr[1:0]);
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (decide) begin
          if (winner == REQ_D) state_nx = win_mis ? ERR_D : BUSY_D;
          else                 state_nx = win_mis ? ERR_I : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: if (mem_ready) state_nx = IDLE;
      ERR_I, ERR_D:   state_nx = IDLE;
      default:        state_nx = IDLE;
    endcase
  end

  // Output decode: next values of the registered pulses plus the live mem_req.
  always_comb begin
    mem_req  = (state == BUSY_I) || (state == BUSY_D);
    i_gnt_nx = decide && (winner == REQ_I);
    d_gnt_nx = decide && (winner == REQ_D);
    i_load   = (state == BUSY_I) && mem_ready;
    d_load   = (state == BUSY_D) && mem_ready && !mem_we;
    i_fin    = ((state == BUSY_I) && mem_ready) || (state == ERR_I);
    d_fin    = ((state == BUSY_D) && mem_ready) || (state == ERR_D);
    i_err_nx = (state == ERR_I);
    d_err_nx = (state == ERR_D);
    mem_load = decide && !win_mis;
    cnt_inc  = decide && (winner == REQ_D) && i_req;
    cnt_clr  = (state == IDLE) && (!i_req || (winner == REQ_I));
  end

  // Registered handshake pulses, read data and the held memory command.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      i_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      i_err     <= 1'b0;
      d_err     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      i_gnt    <= i_gnt_nx;
      d_gnt    <= d_gnt_nx;
      i_rvalid <= i_fin;
      d_rvalid <= d_fin;
      i_err    <= i_err_nx;
      d_err    <= d_err_nx;
      if (i_load) i_rdata <= mem_rdata;
      if (d_load) d_rdata <= mem_rdata;
      if (mem_load) begin
        mem_addr  <= win_addr[ADDR_W-1:2];
        mem_we    <= (winner == REQ_D) && d_we;
        mem_wdata <= (winner == REQ_D) ? d_wdata : '0;
      end
    end
  end

endmodule
